low_power_control_unit: RTL and testbench
=========================================

Name: low_power_control_unit

Overview:
Registered instruction-decode control unit for a small 4-bit-opcode datapath. It produces the datapath control signals: register write, memory read/write, ALU source select, ALU operation, branch and jump. For low power, the output registers load only when a valid instruction is presented and otherwise hold their value, so control lines do not toggle on idle or bubble cycles.

Parameters:
None. Opcode width is fixed at 4 and alu_op width at 3.

Ports:
clk        input   1  system clock; all state updates on the rising edge
rst_n      input   1  synchronous reset, active-low
opcode     input   4  instruction opcode, sampled only when valid=1
valid      input   1  opcode qualifier; 1 = decode and load outputs, 0 = hold outputs
reg_write  output  1  register-file write enable
mem_read   output  1  data-memory read enable
mem_write  output  1  data-memory write enable
alu_src    output  1  ALU operand B select; 0 = register, 1 = immediate
alu_op     output  3  ALU operation code
branch     output  1  conditional-branch instruction
jump       output  1  unconditional-jump instruction

Behaviour:
- Interface: one clock; reset is synchronous and active-low.
- Every output is a flop; there is no combinational path from the inputs to the outputs.
- Reset: when rst_n=0 at a rising clk edge, all outputs go to 0 (alu_op = 3'b000). Reset has priority over valid.
- Load: when rst_n=1 and valid=1 at a rising edge, the outputs load the decode of opcode. Latency is 1 cycle: outputs reflect the opcode sampled at the previous edge.
- Hold: when rst_n=1 and valid=0, every output keeps its previous value regardless of opcode. Implement this as a register enable (clock-enable style). The unit has no dependency on any other condition.
- alu_op encoding: ADD=000, SUB=001, AND=010, OR=011, XOR=100, SLL=101, SRL=110; 111 is reserved and never generated.
- Decode table, listed as reg_write, mem_read, mem_write, alu_src, alu_op, branch, jump:
  - 0000 NOP: 0,0,0,0,000,0,0
  - 0001 ADD: 1,0,0,0,000,0,0
  - 0010 SUB: 1,0,0,0,001,0,0
  - 0011 AND: 1,0,0,0,010,0,0
  - 0100 OR: 1,0,0,0,011,0,0
  - 0101 XOR: 1,0,0,0,100,0,0
  - 0110 LOAD: 1,1,0,1,000,0,0 (address = reg + imm)
  - 0111 STORE: 0,0,1,1,000,0,0
  - 1000 BRANCH: 0,0,0,0,001,1,0 (compare by subtract)
  - 1001 JUMP: 0,0,0,0,000,0,1
  - 1010 SLL: 1,0,0,0,101,0,0
  - 1011 SRL: 1,0,0,0,110,0,0
  - 1100–1111 undefined: decode exactly as NOP (all zeros). No error flag is raised.
- Invariants, which hold on every cycle:
  - mem_read and mem_write are never both 1.
  - branch and jump are never both 1.
  - reg_write is never 1 together with mem_write, branch or jump.
- Back-to-back valid instructions are accepted every cycle with no stall or bubble.
- Reset asserted mid-stream clears the outputs at the next edge. After rst_n deasserts, the outputs stay 0 until the first valid=1 edge.
- Inputs that are X while valid=0 must not propagate X to the outputs.

Test Plan:
1. Reset: hold rst_n=0 for 2 cycles with valid=1, opcode=0001 -> all outputs 0, alu_op=000. Release rst_n with valid=0 -> outputs stay 0.
2. Opcode sweep: valid=1, apply each opcode 0000–1011 for 2 cycles -> outputs match the decode table one cycle after each change. Examples: LOAD -> reg_write=1, mem_read=1, alu_src=1, alu_op=000; BRANCH -> branch=1, alu_op=001; SRL -> reg_write=1, alu_op=110.
3. Hold: after SRL is loaded, set valid=0 and opcode=0001 for 2+ cycles -> outputs remain at the SRL values (reg_write=1, alu_op=110); no output toggles.
4. Undefined opcodes: valid=1, opcode=1100..1111 following STORE -> all outputs 0 one cycle later.
5. Back-to-back plus mid-stream reset: valid=1 with opcode ADD, STORE, JUMP on consecutive cycles -> outputs follow with 1-cycle latency. Then assert rst_n=0 for one cycle while valid=1 -> outputs 0 at that edge.
6. Invariant check: random opcode, valid and rst_n for 1000 cycles -> scoreboard matches the decode model, and no invariant is ever violated.

Source files
------------

// File: rtl/low_power_control_unit.sv
//------------------------------------------------------------------------------
// low_power_control_unit
//
// Registered instruction-decode control unit for a 4-bit-opcode datapath.
// The control word is decoded combinationally from the opcode. It is captured
// into the output flops only on cycles where valid is high. On idle or bubble
// cycles the flops are not enabled, so the control lines stay quiet.
//
// Ports:
//   clk        in   1  system clock, rising edge
//   rst_n      in   1  synchronous reset, active-low (priority over valid)
//   opcode     in   4  instruction opcode, sampled only when valid=1
//   valid      in   1  1 = decode and load outputs, 0 = hold outputs
//   reg_write  out  1  register-file write enable
//   mem_read   out  1  data-memory read enable
//   mem_write  out  1  data-memory write enable
//   alu_src    out  1  ALU operand B select (0 = register, 1 = immediate)
//   alu_op     out  3  ALU operation code
//   branch     out  1  conditional-branch instruction
//   jump       out  1  unconditional-jump instruction
//------------------------------------------------------------------------------
module low_power_control_unit (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] opcode,
    input  logic       valid,
    output logic       reg_write,
    output logic       mem_read,
    output logic       mem_write,
    output logic       alu_src,
    output logic [2:0] alu_op,
    output logic       branch,
    output logic       jump
);

    // ALU operation encodings; 3'b111 is reserved and never produced.
    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;
    localparam logic [2:0] ALU_SLL = 3'b101;
    localparam logic [2:0] ALU_SRL = 3'b110;

    // Packed control word layout:
    // {reg_write, mem_read, mem_write, alu_src, alu_op[2:0], branch, jump}
    logic [8:0] ctrl_s;
    logic [8:0] ctrl_r;

    // Opcode decode; undefined opcodes fall into the all-zero (NOP) word.
    always_comb begin
        ctrl_s = 9'b0_0_0_0_000_0_0;
        case (opcode)
            4'b0000: ctrl_s = {1'b0, 1'b0, 1'b0, 1'b0, ALU_ADD, 1'b0, 1'b0}; // NOP
            4'b0001: ctrl_s = {1'b1, 1'b0, 1'b0, 1'b0, ALU_ADD, 1'b0, 1'b0}; // ADD
            4'b0010: ctrl_s = {1'b1, 1'b0, 1'b0, 1'b0, ALU_SUB, 1'b0, 1'b0}; // SUB
            4'b0011: ctrl_s = {1'b1, 1'b0, 1'b0, 1'b0, ALU_AND, 1'b0, 1'b0}; // AND
            4'b0100: ctrl_s = {1'b1, 1'b0, 1'b0, 1'b0, ALU_OR,  1'b0, 1'b0}; // OR
            4'b0101: ctrl_s = {1'b1, 1'b0, 1'b0, 1'b0, ALU_XOR, 1'b0, 1'b0}; // XOR
            // LOAD: address is reg + imm, so the ALU adds with the immediate.
            4'b0110: ctrl_s = {1'b1, 1'b1, 1'b0, 1'b1, ALU_ADD, 1'b0, 1'b0};
            // STORE: same address computation, no register writeback.
            4'b0111: ctrl_s = {1'b0, 1'b0, 1'b1, 1'b1, ALU_ADD, 1'b0, 1'b0};
            // BRANCH: operands are compared by subtraction.
            4'b1000: ctrl_s = {1'b0, 1'b0, 1'b0, 1'b0, ALU_SUB, 1'b1, 1'b0};
            4'b1001: ctrl_s = {1'b0, 1'b0, 1'b0, 1'b0, ALU_ADD, 1'b0, 1'b1}; // JUMP
            4'b1010: ctrl_s = {1'b1, 1'b0, 1'b0, 1'b0, ALU_SLL, 1'b0, 1'b0}; // SLL
            4'b1011: ctrl_s = {1'b1, 1'b0, 1'b0, 1'b0, ALU_SRL, 1'b0, 1'b0}; // SRL
            default: ctrl_s = 9'b0_0_0_0_000_0_0;                             // undefined
        endcase
    end

    // Control-word register: reset clears it, valid acts as the load enable,
    // otherwise it holds (the opcode is never looked at while valid is low).
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ctrl_r <= 9'b0_0_0_0_000_0_0;
        end else if (valid) begin
            ctrl_r <= ctrl_s;
        end else begin
            ctrl_r <= ctrl_r;
        end
    end

    assign reg_write = ctrl_r[8];
    assign mem_read  = ctrl_r[7];
    assign mem_write = ctrl_r[6];
    assign alu_src   = ctrl_r[5];
    assign alu_op    = ctrl_r[4:2];
    assign branch    = ctrl_r[1];
    assign jump      = ctrl_r[0];

endmodule

// File: tb/tb_low_power_control_unit.sv
//------------------------------------------------------------------------------
// tb_low_power_control_unit
//
// Directed plus random self-checking bench for low_power_control_unit.
// Expected control words come from a hand-written decode table and a small
// reference register that follows reset / load / hold.
//------------------------------------------------------------------------------
module tb_low_power_control_unit;

    logic       clk;
    logic       rst_n;
    logic [3:0] opcode;
    logic       valid;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       alu_src;
    logic [2:0] alu_op;
    logic       branch;
    logic       jump;

    int assert_cnt;
    int fail_cnt;

    logic [8:0] tbl_r [16];
    logic [8:0] model_r;
    logic [8:0] obs_s;
    logic       inv_s;

    low_power_control_unit dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .opcode    (opcode),
        .valid     (valid),
        .reg_write (reg_write),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .alu_src   (alu_src),
        .alu_op    (alu_op),
        .branch    (branch),
        .jump      (jump)
    );

    // Free-running clock, 10 time-unit period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign obs_s = {reg_write, mem_read, mem_write, alu_src, alu_op, branch, jump};
    assign inv_s = !(mem_read && mem_write) && !(branch && jump) &&
                   !(reg_write && (mem_write || branch || jump));

    // Builds a control word from the columns of the decode table.
    function automatic logic [8:0] cw(input logic rw, input logic mr, input logic mw,
                                      input logic as, input logic [2:0] op,
                                      input logic br, input logic jp);
        return {rw, mr, mw, as, op, br, jp};
    endfunction

    // Single comparison point: counts and reports mismatches (4-state compare).
    task automatic check_val(input string tag, input logic [8:0] obs, input logic [8:0] exp);
        assert_cnt++;
        if (obs !== exp) begin
            fail_cnt++;
            $display("FAIL %s: got %b expected %b (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Drive one cycle of inputs, clock it, update the reference, settle #1.
    task automatic apply(input logic r, input logic v, input logic [3:0] op);
        rst_n  = r;
        valid  = v;
        opcode = op;
        @(posedge clk);
        if (!r)
            model_r = 9'd0;
        else if (v)
            model_r = tbl_r[op];
        #1;
    endtask

    initial begin
        assert_cnt = 0;
        fail_cnt   = 0;
        model_r    = 9'd0;
        rst_n      = 1'b0;
        valid      = 1'b0;
        opcode     = 4'd0;

        // Hand-entered decode table: rw, mr, mw, as, alu_op, br, jp
        tbl_r[0]  = cw(1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0); // NOP
        tbl_r[1]  = cw(1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0); // ADD
        tbl_r[2]  = cw(1'b1, 1'b0, 1'b0, 1'b0, 3'b001, 1'b0, 1'b0); // SUB
        tbl_r[3]  = cw(1'b1, 1'b0, 1'b0, 1'b0, 3'b010, 1'b0, 1'b0); // AND
        tbl_r[4]  = cw(1'b1, 1'b0, 1'b0, 1'b0, 3'b011, 1'b0, 1'b0); // OR
        tbl_r[5]  = cw(1'b1, 1'b0, 1'b0, 1'b0, 3'b100, 1'b0, 1'b0); // XOR
        tbl_r[6]  = cw(1'b1, 1'b1, 1'b0, 1'b1, 3'b000, 1'b0, 1'b0); // LOAD
        tbl_r[7]  = cw(1'b0, 1'b0, 1'b1, 1'b1, 3'b000, 1'b0, 1'b0); // STORE
        tbl_r[8]  = cw(1'b0, 1'b0, 1'b0, 1'b0, 3'b001, 1'b1, 1'b0); // BRANCH
        tbl_r[9]  = cw(1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b1); // JUMP
        tbl_r[10] = cw(1'b1, 1'b0, 1'b0, 1'b0, 3'b101, 1'b0, 1'b0); // SLL
        tbl_r[11] = cw(1'b1, 1'b0, 1'b0, 1'b0, 3'b110, 1'b0, 1'b0); // SRL
        for (int i = 12; i < 16; i++)
            tbl_r[i] = 9'd0;                                          // undefined

        // 1. Reset with valid=1 / ADD, then release with valid=0.
        for (int i = 0; i < 2; i++) begin
            apply(1'b0, 1'b1, 4'b0001);
            check_val("reset", obs_s, 9'd0);
        end
        for (int i = 0; i < 2; i++) begin
            apply(1'b1, 1'b0, 4'b0001);
            check_val("reset_release", obs_s, 9'd0);
        end

        // 2. Opcode sweep, two cycles each.
        for (int op = 0; op < 12; op++) begin
            for (int k = 0; k < 2; k++) begin
                apply(1'b1, 1'b1, 4'(op));
                check_val($sformatf("sweep_op%0d", op), obs_s, model_r);
            end
            if (op == 6)  check_val("load_lit",   obs_s, 9'b1_1_0_1_000_0_0);
            if (op == 8)  check_val("branch_lit", obs_s, 9'b0_0_0_0_001_1_0);
            if (op == 11) check_val("srl_lit",    obs_s, 9'b1_0_0_0_110_0_0);
        end

        // 3. Hold after SRL: ADD on opcode, then X on opcode, valid low.
        for (int i = 0; i < 3; i++) begin
            apply(1'b1, 1'b0, 4'b0001);
            check_val("hold", obs_s, 9'b1_0_0_0_110_0_0);
        end
        for (int i = 0; i < 2; i++) begin
            apply(1'b1, 1'b0, 4'bxxxx);
            check_val("hold_x", obs_s, 9'b1_0_0_0_110_0_0);
        end

        // 4. Undefined opcodes after STORE.
        apply(1'b1, 1'b1, 4'b0111);
        check_val("store", obs_s, 9'b0_0_1_1_000_0_0);
        for (int op = 12; op < 16; op++) begin
            apply(1'b1, 1'b1, 4'(op));
            check_val($sformatf("undef_op%0d", op), obs_s, 9'd0);
            apply(1'b1, 1'b1, 4'b0111);
        end

        // 5. Back-to-back ADD, STORE, JUMP then mid-stream reset.
        apply(1'b1, 1'b1, 4'b0001);
        check_val("b2b_add", obs_s, 9'b1_0_0_0_000_0_0);
        apply(1'b1, 1'b1, 4'b0111);
        check_val("b2b_store", obs_s, 9'b0_0_1_1_000_0_0);
        apply(1'b1, 1'b1, 4'b1001);
        check_val("b2b_jump", obs_s, 9'b0_0_0_0_000_0_1);
        apply(1'b0, 1'b1, 4'b0001);
        check_val("midreset", obs_s, 9'd0);
        apply(1'b1, 1'b0, 4'b0110);
        check_val("post_reset_idle", obs_s, 9'd0);

        // 6. Random traffic against the reference, plus invariants.
        for (int i = 0; i < 1000; i++) begin
            apply(($urandom_range(0, 15) != 0) ? 1'b1 : 1'b0,
                  1'($urandom_range(0, 1)),
                  4'($urandom_range(0, 15)));
            check_val("rand_model", obs_s, model_r);
            check_val("invariant", {8'd0, inv_s}, 9'd1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
        $finish;
    end

endmodule
